// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 receiver sampled on a 4x baud strobe, feeding a NUM-deep byte FIFO.
module uart_rx_fifo #(
    parameter int NUM  = 8,
    parameter int BITS = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            baud_x4,
    input  logic            serial,
    output logic [7:0]      data,
    output logic            data_valid,
    input  logic            data_read,
    output logic [BITS:0]   count,
    output logic            overflow,
    output logic            framing_error
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    logic [1:0]      sync_q;
    logic [2:0]      state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      mem_q [NUM];
    logic [BITS-1:0] wr_q, rd_q;
    logic [BITS:0]   count_q, count_d;
    logic            ovf_q, ovf_d, fe_q, fe_d;
    logic            rx, push, pop, full, wr_en;

    assign rx = sync_q[1];

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        fe_d    = 1'b0;
        if (baud_x4) begin
            phase_d = phase_q + 2'd1;
            case (state_q)
                IDLE: if (!rx) begin
                    state_d = START;
                    phase_d = 2'd0;
                end
                START: if (phase_q == 2'd1) begin
                    state_d = rx ? IDLE : DATA;
                    phase_d = 2'd0;
                    bit_d   = 3'd0;
                end
                DATA: if (phase_q == 2'd3) begin
                    shift_d[bit_q] = rx;
                    bit_d          = bit_q + 3'd1;
                    state_d        = (bit_q == 3'd7) ? STOP : DATA;
                end
                STOP: if (phase_q == 2'd3) begin
                    push    = rx;
                    fe_d    = !rx;
                    state_d = rx ? IDLE : BRK;
                end
                default: state_d = rx ? IDLE : BRK;
            endcase
        end
    end

    // A push at full still lands when the same edge frees a slot.
    assign pop     = data_read && (count_q != '0);
    assign full    = count_q == (BITS+1)'(NUM);
    assign wr_en   = push && (!full || pop);
    assign ovf_d   = push && full && !pop;
    assign count_d = count_q + (BITS+1)'(wr_en) - (BITS+1)'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], serial};
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wr_q    <= wr_q + BITS'(wr_en);
            rd_q    <= rd_q + BITS'(pop);
            count_q <= count_d;
            ovf_q   <= ovf_d;
            fe_q    <= fe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= shift_q;
    end

    assign data          = mem_q[rd_q];
    assign data_valid    = count_q != '0;
    assign count         = count_q;
    assign overflow      = ovf_q;
    assign framing_error = fe_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives 8N1 frames into NUM=8 and NUM=4 receivers and checks both against a queue model.
module tb_uart_rx_fifo;
    logic       clk = 1'b0, reset = 1'b1, baud_x4 = 1'b0, serial = 1'b1, data_read = 1'b0;
    logic [7:0] data8, data4;
    logic       dv8, dv4, ovf8, ovf4, fe8, fe4;
    logic [3:0] cnt8;
    logic [2:0] cnt4;

    always #5 clk = ~clk;

    uart_rx_fifo #(.NUM(8), .BITS(3)) dut8 (
        .clk(clk), .reset(reset), .baud_x4(baud_x4), .serial(serial), .data(data8),
        .data_valid(dv8), .data_read(data_read), .count(cnt8), .overflow(ovf8), .framing_error(fe8));
    uart_rx_fifo #(.NUM(4), .BITS(2)) dut4 (
        .clk(clk), .reset(reset), .baud_x4(baud_x4), .serial(serial), .data(data4),
        .data_valid(dv4), .data_read(data_read), .count(cnt4), .overflow(ovf4), .framing_error(fe4));

    int vectors = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: receiver tracked by strobes counted since the start edge was seen.
    logic [1:0] m_sh = 2'b11;
    bit         m_busy = 0, m_brk = 0, m_fe = 0;
    int         m_n = 0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] mq [2][$];
    int         depth [2] = '{8, 4};
    bit         m_ovf [2] = '{0, 0};

    always @(posedge clk) begin : model
        bit rx, push, pop;
        if (reset) begin
            m_sh = 2'b11; m_busy = 0; m_brk = 0; m_n = 0; m_byte = 8'h00; m_fe = 0;
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                m_ovf[i] = 0;
            end
        end else begin
            rx = m_sh[1];
            m_sh = {m_sh[0], serial};
            push = 0;
            m_fe = 0;
            if (baud_x4) begin
                if (m_brk) m_brk = !rx;
                else if (!m_busy) begin
                    if (!rx) begin
                        m_busy = 1;
                        m_n = 0;
                    end
                end else begin
                    m_n++;
                    if (m_n == 2 && rx) m_busy = 0;
                    else if (m_n > 2 && m_n < 38 && (m_n - 2) % 4 == 0) m_byte[3'((m_n - 2) / 4 - 1)] = rx;
                    else if (m_n == 38) begin
                        m_busy = 0;
                        push = rx;
                        m_fe = !rx;
                        m_brk = !rx;
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                pop = data_read && mq[i].size() != 0;
                m_ovf[i] = push && mq[i].size() == depth[i] && !pop;
                if (pop) void'(mq[i].pop_front());
                if (push && !m_ovf[i]) mq[i].push_back(m_byte);
            end
        end
    end

    int fe_cnt = 0, ovf_cnt4 = 0, ovf_cnt8 = 0;

    always begin
        @(posedge clk);
        #1;
        chk("count8", 32'(cnt8), 32'(mq[0].size()));
        chk("valid8", 32'(dv8), 32'(mq[0].size() != 0));
        if (mq[0].size() != 0) chk("data8", 32'(data8), 32'(mq[0][0]));
        chk("ovf8", 32'(ovf8), 32'(m_ovf[0]));
        chk("fe8", 32'(fe8), 32'(m_fe));
        chk("count4", 32'(cnt4), 32'(mq[1].size()));
        chk("valid4", 32'(dv4), 32'(mq[1].size() != 0));
        if (mq[1].size() != 0) chk("data4", 32'(data4), 32'(mq[1][0]));
        chk("ovf4", 32'(ovf4), 32'(m_ovf[1]));
        chk("fe4", 32'(fe4), 32'(m_fe));
        fe_cnt   += int'(fe8);
        ovf_cnt4 += int'(ovf4);
        ovf_cnt8 += int'(ovf8);
    end

    int bcnt = 0, pop_req_n = 0, pop_done_n = 0;
    bit rd_rand = 0, pp_arm = 0;

    always @(negedge clk) begin
        bcnt = (bcnt + 1) % 8;
        baud_x4 = bcnt == 0;
        data_read = (rd_rand && $urandom_range(3) == 0) || (pop_req_n != pop_done_n) ||
                    (pp_arm && baud_x4 && m_busy && m_n == 37);
        if (pop_req_n != pop_done_n) pop_done_n++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bitp(input logic v);
        serial = v;
        clks(32);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        bitp(1'b0);
        for (int i = 0; i < 8; i++) bitp(b[i]);
        bitp(stop);
        serial = 1'b1;
    endtask

    task automatic pop_check(input string name, input bit four, input logic [7:0] exp);
        chk(name, 32'(four ? data4 : data8), 32'(exp));
        pop_req_n++;
        clks(2);
    endtask

    initial begin
        int f0, o0;
        logic [7:0] b;
        clks(4);
        chk("rst_cnt8", 32'(cnt8), 0);
        chk("rst_dv8", 32'(dv8), 0);
        chk("rst_ovf4", 32'(ovf4), 0);
        reset = 1'b0;
        clks(20);
        send(8'hA5, 1'b1);
        clks(8);
        chk("a5_cnt", 32'(cnt8), 1);
        chk("a5_dv", 32'(dv8), 1);
        pop_check("a5_data", 0, 8'hA5);
        chk("a5_empty", 32'(dv8), 0);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        clks(8);
        chk("b2b_cnt", 32'(cnt8), 3);
        pop_check("b2b_0", 0, 8'h00);
        pop_check("b2b_1", 0, 8'hFF);
        pop_check("b2b_2", 0, 8'h55);
        f0 = fe_cnt;
        serial = 1'b0;
        clks(8);
        serial = 1'b1;
        clks(64);
        chk("glitch_cnt", 32'(cnt8), 0);
        send(8'h3C, 1'b1);
        clks(8);
        pop_check("glitch_3c", 0, 8'h3C);
        chk("glitch_fe", 32'(fe_cnt - f0), 0);
        send(8'h81, 1'b0);
        serial = 1'b0;
        clks(320);
        serial = 1'b1;
        clks(64);
        send(8'h42, 1'b1);
        clks(8);
        chk("brk_fe_once", 32'(fe_cnt - f0), 1);
        chk("brk_cnt", 32'(cnt8), 1);
        pop_check("brk_42", 0, 8'h42);
        o0 = ovf_cnt4;
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b1);
        clks(8);
        chk("ovf_cnt4", 32'(cnt4), 4);
        chk("ovf_pulse", 32'(ovf_cnt4 - o0), 1);
        chk("ovf_cnt8", 32'(cnt8), 5);
        for (int i = 0; i < 4; i++) pop_check("ovf_rd", 1, 8'h10 + 8'(i));
        pop_check("ovf_14", 0, 8'h14);
        send(8'h1F, 1'b1);
        clks(8);
        pop_check("wrap_1f", 1, 8'h1F);
        for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 1'b1);
        clks(8);
        for (int i = 0; i < 4; i++) pop_check("wrap_rd", 1, 8'h20 + 8'(i));
        for (int i = 0; i < 4; i++) send(8'h30 + 8'(i), 1'b1);
        o0 = ovf_cnt4;
        pp_arm = 1;
        send(8'h34, 1'b1);
        pp_arm = 0;
        clks(8);
        chk("pp_cnt4", 32'(cnt4), 4);
        chk("pp_no_ovf", 32'(ovf_cnt4 - o0), 0);
        for (int i = 1; i < 5; i++) pop_check("pp_rd", 1, 8'h30 + 8'(i));
        send(8'h50, 1'b1);
        send(8'h51, 1'b1);
        clks(8);
        chk("mid_pre", 32'(cnt8), 2);
        f0 = fe_cnt;
        o0 = ovf_cnt8;
        b = 8'h6A;
        bitp(1'b0);
        for (int i = 0; i < 4; i++) bitp(b[i]);
        serial = b[4];
        clks(16);
        reset = 1'b1;
        serial = 1'b1;
        clks(2);
        reset = 1'b0;
        chk("mid_cnt8", 32'(cnt8), 0);
        chk("mid_dv8", 32'(dv8), 0);
        chk("mid_cnt4", 32'(cnt4), 0);
        clks(20);
        send(8'h99, 1'b1);
        clks(8);
        chk("mid_pulses", 32'(fe_cnt - f0 + ovf_cnt8 - o0), 0);
        pop_check("mid_99", 0, 8'h99);
        rd_rand = 1;
        repeat (30) begin
            if ($urandom_range(9) == 0) begin
                serial = 1'b0;
                clks($urandom_range(12, 4));
                serial = 1'b1;
                clks(40);
            end
            send(8'($urandom), $urandom_range(9) != 0);
            clks($urandom_range(40));
        end
        clks(200);
        rd_rand = 0;
        clks(20);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive side of the board's serial console: deserialises 8N1 async frames from the synchronised RX pin using a 4x oversampling strobe.
- Pushes good bytes into an NUM-deep FIFO that the consumer drains with a read strobe.
- Pairs with uart_tx_fifo on the same pmod link; baud_x4 comes from the same divide_by_n tree (e.g. N=24 for 1 Mb/s at 96 MHz).

Parameters:
- NUM, 8, FIFO depth in bytes; power of two, >=2.
- BITS, 3, log2(NUM); pointer width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- baud_x4  input  1  one-clk strobe at 4x the bit rate.
- serial  input  1  raw RX pin; idle high; asynchronous to clk.
- data  output  8  FIFO head byte; valid only while data_valid.
- data_valid  output  1  FIFO non-empty.
- data_read  input  1  pop strobe; ignored when data_valid=0.
- count  output  BITS+1  bytes currently held, 0..NUM.
- overflow  output  1  one-clk pulse: completed byte dropped because FIFO full.
- framing_error  output  1  one-clk pulse: stop bit sampled low.

Behaviour:
- Input synchroniser:
  - serial passes through 2 flops, both reset to 1.
  - All decisions use the second flop (rx).
  - Pin-to-rx latency is 2 clk.
- Sampling: the FSM advances only on clk edges with baud_x4=1. A 2-bit phase counter counts strobes.
- IDLE: on a strobe with rx=0, go to START with phase=0.
- START: after 2 strobes (mid-bit), sample rx.
  - rx=1: false start, return to IDLE, nothing reported.
  - rx=0: go to DATA with bit index=0 and phase=0.
- DATA: every 4th strobe, sample rx into shift[bit], LSB first. After bit 7, go to STOP.
- STOP: 4 strobes later, sample rx.
  - rx=1: push the byte on that same clk edge, go to IDLE.
  - rx=0: pulse framing_error, discard the byte, go to BREAK.
- BREAK: wait for a strobe with rx=1, then go to IDLE. A held-low line (break) yields exactly one framing_error.
- FIFO:
  - Circular buffer with BITS-wide read/write pointers and an explicit count register.
  - data = mem[rd_ptr], combinational from registers.
  - data_valid = (count != 0).
  - Pointers wrap modulo NUM.
- Push/pop interaction:
  - Push when count=NUM and no pop: byte dropped, overflow pulses, FIFO contents unchanged.
  - Push and pop on the same clk when count=NUM: both happen, count stays NUM, no overflow.
  - Push and pop on the same clk when 0<count<NUM: count unchanged.
  - data_read while count=0: no effect; count never underflows.
- Latency: data_valid rises the clk after the stop-sample edge (push edge). A popped byte's successor appears on data the clk after data_read.
- Reset values:
  - State=IDLE; pointers, count and shift = 0.
  - Synchroniser flops = 1.
  - data_valid, overflow, framing_error = 0. data is don't-care but driven from mem[0].
  - Reset mid-frame abandons the frame; no pulse is generated, and the FIFO is emptied.
- baud_x4 and data_read are independent; pops proceed during reception.

Test Plan:
- Single byte: NUM=8, baud_x4 every 8 clk. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> data_valid rises 1 clk after the stop sample, data=0xA5, count=1. data_read -> count=0, data_valid=0.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> all three read in order, no framing_error.
- Glitch: rx low for 1 baud_x4 period, then high -> return to IDLE. No push, no framing_error; a following 0x3C is received correctly.
- Framing: 0x81 with stop=0, then line held low for 40 strobes, then high, then a good 0x42 -> exactly one framing_error pulse. FIFO holds only 0x42.
- Overflow/wrap: NUM=4, send 5 bytes 0x10..0x14 with no reads -> count=4, one overflow pulse on the 5th push. Reads return 0x10..0x13. Then send 0x20..0x23 across the pointer wrap -> read back in order. Also cover pop on the same edge as a push at full -> count=4, no overflow.
- Reset mid-frame: assert reset during DATA bit 4 while FIFO holds 2 bytes -> count=0, data_valid=0, no pulses. A subsequent 0x99 is received cleanly.
